// File: rtl/ahb_bus_matrix_ingress_s2_if.sv
// Bundles the master-facing AHB slave port and the decoder-facing address-phase signals of one matrix ingress stage.
// The slave modport is the ingress stage itself; the master modport is whatever drives it.
interface ahb_bus_matrix_ingress_s2_if;
    logic        HSELS;
    logic [31:0] HADDRS;
    logic [1:0]  HTRANSS;
    logic        HWRITES;
    logic [2:0]  HSIZES;
    logic [3:0]  HPROTS;
    logic        HREADYS;
    logic        HREADYOUTS;
    logic [1:0]  HRESPS;
    logic        sel_op;
    logic [31:0] addr_op;
    logic [1:0]  trans_op;
    logic        write_op;
    logic [2:0]  size_op;
    logic [3:0]  prot_op;
    logic        held_tran_op;
    logic        active_op;
    logic        readyout_op;
    logic [1:0]  resp_op;

    modport slave (
        input  HSELS, HADDRS, HTRANSS, HWRITES, HSIZES, HPROTS, HREADYS,
        output HREADYOUTS, HRESPS,
        output sel_op, addr_op, trans_op, write_op, size_op, prot_op, held_tran_op,
        input  active_op, readyout_op, resp_op
    );

    modport master (
        output HSELS, HADDRS, HTRANSS, HWRITES, HSIZES, HPROTS, HREADYS,
        input  HREADYOUTS, HRESPS,
        input  sel_op, addr_op, trans_op, write_op, size_op, prot_op, held_tran_op,
        output active_op, readyout_op, resp_op
    );
endinterface

// File: rtl/ahb_bus_matrix_ingress_s2.sv
// AHB bus-matrix ingress stage: passes granted transfers straight through, otherwise holds the address phase until granted.
// Optional HOLD timeout with a two-cycle ERROR response is compiled in by defining AHB_MTX_INGRESS_TIMEOUT_EN.
module ahb_bus_matrix_ingress_s2 #(
    parameter logic [7:0] HOLD_TIMEOUT = 8'd255
) (
    input  logic                           HCLK,
    input  logic                           HRESETn,
    ahb_bus_matrix_ingress_s2_if.slave     bus
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        DATA = 3'd1,
        HOLD = 3'd2,
        ERR1 = 3'd3,
        ERR2 = 3'd4
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] addr_reg;
    logic [1:0]  trans_reg;
    logic        write_reg;
    logic [2:0]  size_reg;
    logic [3:0]  prot_reg;
    logic        live_req;
    logic        hold_load;
    logic        timeout_hit;

    assign live_req  = bus.HSELS & bus.HTRANSS[1] & bus.HREADYS;
    assign hold_load = ((state_reg == IDLE) || (state_reg == DATA)) && (state_next == HOLD);

`ifdef AHB_MTX_INGRESS_TIMEOUT_EN
    logic [7:0] cnt_reg;

    // Counter is held at zero outside HOLD, so it starts from zero on every HOLD entry.
    assign timeout_hit = (cnt_reg >= (HOLD_TIMEOUT - 8'd1));

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            cnt_reg <= 8'd0;
        end else if (state_reg == HOLD) begin
            cnt_reg <= cnt_reg + 8'd1;
        end else begin
            cnt_reg <= 8'd0;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state_reg <= IDLE;
            addr_reg  <= 32'd0;
            trans_reg <= 2'b00;
            write_reg <= 1'b0;
            size_reg  <= 3'd0;
            prot_reg  <= 4'd0;
        end else begin
            state_reg <= state_next;
            if (hold_load) begin
                addr_reg  <= bus.HADDRS;
                trans_reg <= bus.HTRANSS;
                write_reg <= bus.HWRITES;
                size_reg  <= bus.HSIZES;
                prot_reg  <= bus.HPROTS;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE, DATA: begin
                if ((state_reg == DATA) && !bus.HREADYS) begin
                    state_next = DATA;
                end else if (live_req) begin
                    state_next = bus.active_op ? DATA : HOLD;
                end else begin
                    state_next = IDLE;
                end
            end
            HOLD: begin
                // A grant always wins over an expiring timeout in the same cycle.
                if (bus.active_op && bus.readyout_op) begin
                    state_next = DATA;
                end else if (timeout_hit) begin
                    state_next = ERR1;
                end
            end
`ifdef AHB_MTX_INGRESS_TIMEOUT_EN
            ERR1:    state_next = ERR2;
            ERR2:    state_next = IDLE;
`endif
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.held_tran_op = 1'b0;
        bus.sel_op       = bus.HSELS;
        bus.addr_op      = bus.HADDRS;
        bus.trans_op     = bus.HTRANSS;
        bus.write_op     = bus.HWRITES;
        bus.size_op      = bus.HSIZES;
        bus.prot_op      = bus.HPROTS;
        bus.HREADYOUTS   = 1'b1;
        bus.HRESPS       = 2'b00;
        case (state_reg)
            DATA: begin
                bus.HREADYOUTS = bus.readyout_op;
                bus.HRESPS     = bus.resp_op;
            end
            HOLD: begin
                bus.held_tran_op = 1'b1;
                bus.sel_op       = 1'b1;
                bus.addr_op      = addr_reg;
                // The burst was broken by arbitration, so a held SEQ restarts as NONSEQ.
                bus.trans_op     = (trans_reg == 2'b11) ? 2'b10 : trans_reg;
                bus.write_op     = write_reg;
                bus.size_op      = size_reg;
                bus.prot_op      = prot_reg;
                bus.HREADYOUTS   = 1'b0;
            end
            ERR1: begin
                bus.sel_op     = 1'b0;
                bus.HREADYOUTS = 1'b0;
                bus.HRESPS     = 2'b01;
            end
            ERR2: begin
                bus.sel_op     = 1'b0;
                bus.HREADYOUTS = 1'b1;
                bus.HRESPS     = 2'b01;
            end
            default: ;
        endcase
    end

endmodule
